// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX operand capture with writeback bypass, load-use bubble and flush
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_use_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [7:0]      in_ctrl,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_valid,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op_a,
    output logic [XLEN-1:0] out_op_b,
    output logic [XLEN-1:0] out_imm,
    output logic [RA_W-1:0] out_rs1,
    output logic [RA_W-1:0] out_rs2,
    output logic [RA_W-1:0] out_rd,
    output logic [7:0]      out_ctrl,
    output logic            hazard_stall,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int CTRL_MEM_READ = 6;

    typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  pc_q, op_a_q, op_b_q, imm_q;
    logic [RA_W-1:0]  rs1_q, rs2_q, rd_q;
    logic [7:0]       ctrl_q;

    logic [XLEN-1:0]  op_a_sel, op_b_sel;
    logic             haz, in_ready_c, bubble_c, load;

    // x0 reads as zero; a same-cycle writeback wins over the (stale) register file
    always_comb begin
        op_a_sel = rf_rdata1;
        if (in_rs1 == '0)
            op_a_sel = '0;
        else if (wb_valid && wb_rd == in_rs1)
            op_a_sel = wb_data;
        op_b_sel = rf_rdata2;
        if (in_rs2 == '0)
            op_b_sel = '0;
        else if (wb_valid && wb_rd == in_rs2)
            op_b_sel = wb_data;
    end

    assign haz = out_valid_q && ctrl_q[CTRL_MEM_READ] && (rd_q != '0) && in_valid &&
                 ((rd_q == in_rs1) || (in_use_rs2 && rd_q == in_rs2));

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        bubble_c    = 1'b0;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            RUN: begin
                in_ready_c = (!out_valid_q || ex_ready) && !haz && !flush;
                if (haz && ex_ready && !flush)
                    state_d = BUBBLE;
            end
            BUBBLE: begin
                state_d  = RUN;
                bubble_c = !flush;
                if (!flush && cnt_q != {CNT_W{1'b1}})
                    cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = RUN;
        endcase
        load = in_valid && in_ready_c;
        if (flush)
            out_valid_d = 1'b0;
        else if (load)
            out_valid_d = 1'b1;
        else if (out_valid_q && ex_ready)
            out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    // Payload only moves on an accepted instruction; flush clears just the valid bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            imm_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
            ctrl_q <= '0;
        end else if (load) begin
            pc_q   <= in_pc;
            op_a_q <= op_a_sel;
            op_b_q <= op_b_sel;
            imm_q  <= in_imm;
            rs1_q  <= in_rs1;
            rs2_q  <= in_rs2;
            rd_q   <= in_rd;
            ctrl_q <= in_ctrl;
        end
    end

    assign in_ready     = in_ready_c && rst_n;
    assign hazard_stall = bubble_c;
    // The bubble in progress is already visible in the count; a flush withdraws it
    assign stall_cnt    = cnt_d;
    assign out_valid    = out_valid_q;
    assign out_pc       = pc_q;
    assign out_op_a     = op_a_q;
    assign out_op_b     = op_b_q;
    assign out_imm      = imm_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_rd       = rd_q;
    assign out_ctrl     = ctrl_q;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Operand-capture stage directly downstream of the register file.
- Takes the decoded instruction plus the two register-file read ports. Applies a writeback bypass for the same-cycle register write and zeroes x0 operands. Latches the result into a single-entry ID/EX pipeline register with a valid/ready handshake toward the EX stage.
- Detects load-use hazards against the instruction it holds, inserts exactly one bubble per hazard, honours a pipeline flush and keeps a saturating stall counter.

Parameters:
- XLEN, 64, datapath width of PC, operands and immediate
- RA_W, 5, register index width (32 architectural registers)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1, in_rs2, in_rd  in  RA_W  register indices (also driven to register file rs1/rs2)
- in_use_rs2  in  1  instruction actually reads rs2 (R/S/B type)
- in_imm  in  XLEN  sign-extended immediate
- in_ctrl  in  8  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op[2:0]}
- rf_rdata1, rf_rdata2  in  XLEN  register file read data for in_rs1/in_rs2
- wb_valid  in  1  writeback stage writes a register this cycle
- wb_rd  in  RA_W  writeback destination
- wb_data  in  XLEN  writeback data
- flush  in  1  squash held instruction (branch redirect)
- out_valid  out  1  EX-side payload valid
- ex_ready  in  1  EX accepts payload
- out_pc, out_op_a, out_op_b, out_imm  out  XLEN  latched payload
- out_rs1, out_rs2, out_rd  out  RA_W  latched indices (for EX forwarding)
- out_ctrl  out  8  latched control
- hazard_stall  out  1  load-use bubble being inserted this cycle
- stall_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0; all payload outputs 0; stall_cnt=0; FSM to RUN.
  - in_ready reads 0 while rst_n is low.
- Operand select, per operand:
  - index==0 -> 0.
  - Else wb_valid && wb_rd==index -> wb_data.
  - Else rf_rdata.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && ex_ready.
  - Payload and out_valid are stable while out_valid && !ex_ready.
- Hazard (combinational):
  - haz = out_valid && out_ctrl.mem_read && out_rd!=0 && in_valid && (out_rd==in_rs1 || (in_use_rs2 && out_rd==in_rs2)).
- FSM RUN:
  - in_ready = (!out_valid || ex_ready) && !haz && !flush.
  - On input transfer: latch payload, out_valid=1. Latency from input transfer to out_valid is 1 cycle.
  - If the output transfers and there is no input transfer: out_valid=0.
  - If haz && ex_ready: go to BUBBLE; out_valid=0 next cycle.
- FSM BUBBLE (exactly one cycle):
  - in_ready=0; out_valid=0; hazard_stall=1; stall_cnt increments.
  - Next state RUN. The held decode instruction is accepted in RUN, with the bypass supplying load data if writeback is writing it.
- haz && !ex_ready: stay in RUN holding the load; no bubble counted yet.
- flush:
  - Highest priority; any state -> RUN.
  - out_valid=0 next cycle; in_ready=0 during the flush cycle; no input captured.
  - A bubble in progress is cancelled and not counted.
- stall_cnt saturates at all-ones, with no wrap.
- Simultaneous wb write and capture of the same index: the bypass value is captured. The register file updates later; no stale read.
- Payload registers do not reset on flush; only out_valid clears.

Test Plan:
- Reset mid-stream:
  - Stimulus: out_valid=1 holding pc=0x40, assert rst_n=0 between clock edges.
  - Required: out_valid=0, out_pc=0 and stall_cnt=0 immediately, without waiting for a clock edge.
- Back-to-back flow:
  - Stimulus: ex_ready=1, three instructions pc=0x0,0x4,0x8 with rf data 5,7.
  - Required: each appears one cycle after acceptance, out_op_a=5, out_op_b=7, no gaps.
- Bypass and x0:
  - Stimulus 1: rs1=3, rf_rdata1=0x11, wb_valid=1, wb_rd=3, wb_data=0x99. Required: out_op_a=0x99.
  - Stimulus 2: rs2=0, rf_rdata2=0xFF. Required: out_op_b=0.
- Load-use:
  - Stimulus: held `ld x5`, then `add x6,x5,x1` presented.
  - Required: one cycle with hazard_stall=1, out_valid=0, stall_cnt=1; the add issues the next cycle.
  - Stimulus: repeat with in_use_rs2=0 and rs2=5. Required: no stall.
- Backpressure:
  - Stimulus: ex_ready=0 for 4 cycles with a valid payload.
  - Required: payload unchanged, in_ready=0; the next instruction is accepted in the same cycle ex_ready rises.
- Flush during BUBBLE:
  - Stimulus: assert flush in the bubble cycle.
  - Required: out_valid=0, stall_cnt not incremented, in_ready=0 that cycle, FSM in RUN the next cycle.
